// File: rtl/uart_pkg.sv
// Purpose: shared types, codes and helpers for the configurable UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // One-hot FSM encoding.
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_t;

  // parity_mode codes; unlisted codes behave as none.
  localparam logic [2:0] PAR_NONE  = 3'b000;
  localparam logic [2:0] PAR_EVEN  = 3'b001;
  localparam logic [2:0] PAR_ODD   = 3'b010;
  localparam logic [2:0] PAR_MARK  = 3'b011;
  localparam logic [2:0] PAR_SPACE = 3'b100;

  // stop_bits codes; 11 behaves as two stop bits.
  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  // Per-frame line configuration captured alongside the data word.
  typedef struct packed {
    logic [2:0] parity_mode;
    logic [1:0] stop_bits;
  } cfg_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // XOR of the low n bits of d (d is sized for the largest legal word).
  function automatic logic par_xor(input logic [8:0] d, input logic [3:0] n);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < int'(n)) x = x ^ d[i];
    end
    return x;
  endfunction

endpackage

// File: rtl/uart_tx_holdreg.sv
// Purpose: one-entry holding register for a UART frame (data + line config) with valid flag.
// Latency: write visible on o_valid one clk after accept; read clears it on the same edge.
// Backpressure: o_ready = !valid; writes while full are silently dropped.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_wr                    write request (taken only when o_ready=1)
//   i_rd                    consume the held entry (clears valid)
//   i_d/i_data_bits/...     entry fields to capture
//   o_ready, o_valid        empty / full status
//   o_d/o_data_bits/...     held entry fields
module uart_tx_holdreg
  import uart_pkg::*;
#(
  parameter int DBIT_MAX = 8,
  parameter int DBW      = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_wr,
  input  logic                i_rd,
  input  logic [DBIT_MAX-1:0] i_d,
  input  logic [DBW-1:0]      i_data_bits,
  input  logic [2:0]          i_parity_mode,
  input  logic [1:0]          i_stop_bits,
  output logic                o_ready,
  output logic                o_valid,
  output logic [DBIT_MAX-1:0] o_d,
  output logic [DBW-1:0]      o_data_bits,
  output logic [2:0]          o_parity_mode,
  output logic [1:0]          o_stop_bits
);

  logic                r_vld;
  logic [DBIT_MAX-1:0] r_d;
  logic [DBW-1:0]      r_bits;
  cfg_t                r_cfg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld  <= 1'b0;
      r_d    <= '0;
      r_bits <= '0;
      r_cfg  <= '0;
    end else if (i_rd) begin
      r_vld <= 1'b0;
    end else if (i_wr && !r_vld) begin
      r_vld             <= 1'b1;
      r_d               <= i_d;
      r_bits            <= i_data_bits;
      r_cfg.parity_mode <= i_parity_mode;
      r_cfg.stop_bits   <= i_stop_bits;
    end
  end

  assign o_ready       = !r_vld;
  assign o_valid       = r_vld;
  assign o_d           = r_d;
  assign o_data_bits   = r_bits;
  assign o_parity_mode = r_cfg.parity_mode;
  assign o_stop_bits   = r_cfg.stop_bits;

endmodule

// File: rtl/uart_tx_cfg.sv
// Purpose: runtime-configurable UART transmitter (5..DBIT_MAX data bits, parity, 1/1.5/2 stop).
// Latency: start bit on the line 2 clk after accept; back-to-back frames have no idle gap.
// Backpressure: o_tx_ready low while the holding register is full; starts then are dropped.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_tick             baud oversampling pulse, NUM_TICKS per bit
//   i_tx_start         send request, honoured only when o_tx_ready=1
//   i_d_in             frame data, LSB first
//   i_data_bits        data bit count (clamped to 5..DBIT_MAX)
//   i_parity_mode      none/even/odd/mark/space
//   i_stop_bits        1 / 1.5 / 2 stop bits
//   o_tx_ready         holding register empty
//   o_tx_busy          FSM active (registered)
//   o_tx_done          one-clk pulse on the final stop tick
//   o_tx_out           serial line, idle high
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int NUM_TICKS = 16,
  parameter int DBIT_MAX  = 8,
  parameter int DBW       = clog2(DBIT_MAX + 1)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_tick,
  input  logic                i_tx_start,
  input  logic [DBIT_MAX-1:0] i_d_in,
  input  logic [DBW-1:0]      i_data_bits,
  input  logic [2:0]          i_parity_mode,
  input  logic [1:0]          i_stop_bits,
  output logic                o_tx_ready,
  output logic                o_tx_busy,
  output logic                o_tx_done,
  output logic                o_tx_out
);

  // Tick counter must reach 2*NUM_TICKS-1 for two stop bits.
  localparam int SW = clog2(2 * NUM_TICKS);
  localparam logic [SW-1:0] L_BIT = SW'(NUM_TICKS - 1);
  localparam logic [SW-1:0] L_1P5 = SW'(3 * NUM_TICKS / 2 - 1);
  localparam logic [SW-1:0] L_2   = SW'(2 * NUM_TICKS - 1);

  logic                w_hold_vld;
  logic                w_hold_rdy;
  logic [DBIT_MAX-1:0] w_hd;
  logic [DBW-1:0]      w_hbits;
  logic [2:0]          w_hpm;
  logic [1:0]          w_hsb;

  logic [DBW-1:0]      w_eff_bits;
  logic                w_par_x;
  logic                w_par_bit;
  logic                w_par_en;
  logic [SW-1:0]       w_stop_last;
  logic                w_stop_end;
  logic                w_load;

  state_t              r_state;
  logic [SW-1:0]       r_s;
  logic [DBW-1:0]      r_n;
  logic [DBW-1:0]      r_nlast;
  logic [DBIT_MAX-1:0] r_shift;
  logic                r_par_en;
  logic                r_par_bit;
  logic [SW-1:0]       r_stop_last;
  logic                r_tx_out;
  logic                r_done;
  logic                r_busy;

  uart_tx_holdreg #(
    .DBIT_MAX(DBIT_MAX),
    .DBW     (DBW)
  ) u_hold (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_wr         (i_tx_start),
    .i_rd         (w_load),
    .i_d          (i_d_in),
    .i_data_bits  (i_data_bits),
    .i_parity_mode(i_parity_mode),
    .i_stop_bits  (i_stop_bits),
    .o_ready      (w_hold_rdy),
    .o_valid      (w_hold_vld),
    .o_d          (w_hd),
    .o_data_bits  (w_hbits),
    .o_parity_mode(w_hpm),
    .o_stop_bits  (w_hsb)
  );

  // Frame parameters are derived from the held entry so they are ready on the load edge.
  always_comb begin
    w_eff_bits = w_hbits;
    if (w_hbits < DBW'(5))             w_eff_bits = DBW'(5);
    else if (w_hbits > DBW'(DBIT_MAX)) w_eff_bits = DBW'(DBIT_MAX);

    w_par_x   = par_xor(9'(w_hd), 4'(w_eff_bits));
    w_par_bit = 1'b0;
    w_par_en  = 1'b1;
    case (w_hpm)
      PAR_EVEN:  w_par_bit = w_par_x;
      PAR_ODD:   w_par_bit = !w_par_x;
      PAR_MARK:  w_par_bit = 1'b1;
      PAR_SPACE: w_par_bit = 1'b0;
      default:   w_par_en  = 1'b0;
    endcase

    case (w_hsb)
      STOP_1:   w_stop_last = L_BIT;
      STOP_1P5: w_stop_last = L_1P5;
      STOP_2:   w_stop_last = L_2;
      default:  w_stop_last = L_2;
    endcase
  end

  assign w_stop_end = (r_state == S_STOP) && i_tick && (r_s == r_stop_last);
  // Load from IDLE, or straight from the last stop tick for gapless back-to-back frames.
  assign w_load     = w_hold_vld && ((r_state == S_IDLE) || w_stop_end);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_nlast     <= '0;
      r_shift     <= '0;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop_last <= '0;
      r_tx_out    <= 1'b1;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Busy trails the state by one edge, so it drops the clk after tx_done.
      r_busy <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_s <= '0;
        end
        S_START: begin
          if (i_tick) begin
            if (r_s == L_BIT) begin
              r_s      <= '0;
              r_state  <= S_DATA;
              r_tx_out <= r_shift[0];
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (i_tick) begin
            if (r_s == L_BIT) begin
              r_s <= '0;
              if (r_n == r_nlast) begin
                if (r_par_en) begin
                  r_state  <= S_PARITY;
                  r_tx_out <= r_par_bit;
                end else begin
                  r_state  <= S_STOP;
                  r_tx_out <= 1'b1;
                end
              end else begin
                r_n      <= r_n + 1'b1;
                r_shift  <= r_shift >> 1;
                r_tx_out <= r_shift[1];
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (i_tick) begin
            if (r_s == L_BIT) begin
              r_s      <= '0;
              r_state  <= S_STOP;
              r_tx_out <= 1'b1;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (i_tick) begin
            if (r_s == r_stop_last) begin
              r_s     <= '0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_tx_out <= 1'b1;
        end
      endcase

      // Load overrides the end-of-frame transition to IDLE.
      if (w_load) begin
        r_state     <= S_START;
        r_tx_out    <= 1'b0;
        r_s         <= '0;
        r_n         <= '0;
        r_shift     <= w_hd;
        r_nlast     <= w_eff_bits - 1'b1;
        r_par_en    <= w_par_en;
        r_par_bit   <= w_par_bit;
        r_stop_last <= w_stop_last;
      end
    end
  end

  assign o_tx_ready = w_hold_rdy;
  assign o_tx_busy  = r_busy;
  assign o_tx_done  = r_done;
  assign o_tx_out   = r_tx_out;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Purpose: directed self-checking bench for uart_tx_cfg (NUM_TICKS=16, DBIT_MAX=8).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_cfg;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       tx_start;
  logic [7:0] d_in;
  logic [3:0] data_bits;
  logic [2:0] parity_mode;
  logic [1:0] stop_bits;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_out;

  int n_total = 0;
  int n_bad   = 0;
  int tcnt    = 0;

  uart_tx_cfg #(
    .NUM_TICKS(16),
    .DBIT_MAX (8)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_tick       (tick),
    .i_tx_start   (tx_start),
    .i_d_in       (d_in),
    .i_data_bits  (data_bits),
    .i_parity_mode(parity_mode),
    .i_stop_bits  (stop_bits),
    .o_tx_ready   (tx_ready),
    .o_tx_busy    (tx_busy),
    .o_tx_done    (tx_done),
    .o_tx_out     (tx_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every third clk, so two of every three edges are tick gaps.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = (tcnt + 1) % 3;
      tick = (tcnt == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic [2:0] pm,
                      input logic [1:0] sb);
    @(negedge clk);
    d_in        = d;
    data_bits   = nb;
    parity_mode = pm;
    stop_bits   = sb;
    tx_start    = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  // Accept from idle; returns at the negedge just after the load edge.
  task automatic start_frame(input string nm, input logic [7:0] d, input logic [3:0] nb,
                             input logic [2:0] pm, input logic [1:0] sb);
    send(d, nb, pm, sb);
    @(negedge clk);
    chk({nm, "_lat1_line"}, tx_out, 1'b1);
    chk({nm, "_held_rdy"}, tx_ready, 1'b0);
    @(negedge clk);
    chk({nm, "_lat2_line"}, tx_out, 1'b0);
    chk({nm, "_loaded_rdy"}, tx_ready, 1'b1);
  endtask

  // lv[k] is the line level of 16-tick segment k (start, data, parity);
  // the stop segment follows at level 1 for stop_t ticks.
  // Called at the negedge right after the load edge; returns at the negedge after the last stop tick.
  task automatic rx_frame(input string nm, input logic [15:0] lv, input int nseg, input int stop_t);
    int         total;
    int         n;
    int         bud;
    int         early;
    int         j;
    logic       v;
    logic       e;
    logic       tp;
    logic [16:0] obs;
    logic [16:0] seen;
    logic [16:0] rep;
    total = 16 * nseg + stop_t;
    n     = 0;
    bud   = total * 4 + 50;
    early = 0;
    obs   = '0;
    seen  = '0;
    rep   = '0;
    while (n < total && bud > 0) begin
      j = n / 16;
      if (j > nseg) j = nseg;
      e = (j < nseg) ? lv[j] : 1'b1;
      v = tx_out;
      if (!seen[j]) begin
        obs[j]  = v;
        seen[j] = 1'b1;
      end
      if (v !== e && !rep[j]) begin
        obs[j] = v;
        rep[j] = 1'b1;
      end
      if (n > 0 && tx_done) early++;
      tp = tick;
      @(negedge clk);
      if (tp) n++;
      bud--;
    end
    chk({nm, "_ticks"}, n, total);
    for (int k = 0; k <= nseg; k++) begin
      chk($sformatf("%s_seg%0d", nm, k), obs[k], (k < nseg) ? lv[k] : 1'b1);
    end
    chk({nm, "_early_done"}, early, 0);
    chk({nm, "_done"}, tx_done, 1'b1);
  endtask

  initial begin
    int bud;
    int n;
    int lows;
    int dones;
    logic tp;

    reset       = 1'b1;
    tx_start    = 1'b0;
    d_in        = '0;
    data_bits   = 4'd8;
    parity_mode = 3'b000;
    stop_bits   = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_line", tx_out, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1 0xA5, inputs scrambled mid-frame
    start_frame("t1", 8'hA5, 4'd8, 3'b000, 2'b00);
    d_in        = 8'h00;
    data_bits   = 4'd5;
    parity_mode = 3'b010;
    stop_bits   = 2'b10;
    rx_frame("t1", 16'b1_0100_1010, 9, 16);
    chk("t1_busy_at_done", tx_busy, 1'b1);
    @(negedge clk);
    chk("t1_busy_after", tx_busy, 1'b0);
    chk("t1_idle_line", tx_out, 1'b1);

    // 7E1 0xC1: data 1,0,0,0,0,0,1 parity 0
    start_frame("t2", 8'hC1, 4'd7, 3'b001, 2'b00);
    rx_frame("t2", 16'b0_1000_0010, 9, 16);

    // 5O2 0xFF, then data_bits=3 clamps to the same waveform
    start_frame("t3", 8'hFF, 4'd5, 3'b010, 2'b10);
    rx_frame("t3", 16'b011_1110, 7, 32);
    start_frame("t3c", 8'hFF, 4'd3, 3'b010, 2'b10);
    rx_frame("t3c", 16'b011_1110, 7, 32);

    // 8M1.5 0x00 -> parity 1, stop 24; then 8S1 0xFF -> parity 0
    start_frame("t4", 8'h00, 4'd8, 3'b011, 2'b01);
    rx_frame("t4", 16'b10_0000_0000, 10, 24);
    start_frame("t5", 8'hFF, 4'd8, 3'b100, 2'b00);
    rx_frame("t5", 16'b01_1111_1110, 10, 16);

    // back-to-back 0x55 then 0x0F; a third start while full is dropped
    start_frame("b1", 8'h55, 4'd8, 3'b000, 2'b00);
    fork
      begin
        rx_frame("b1", 16'b0_1010_1010, 9, 16);
        chk("b2b_rdy_reload", tx_ready, 1'b1);
        rx_frame("b2", 16'b0_0001_1110, 9, 16);
      end
      begin
        repeat (20) @(negedge clk);
        chk("b2b_rdy_free", tx_ready, 1'b1);
        send(8'h0F, 4'd8, 3'b000, 2'b00);
        @(negedge clk);
        chk("b2b_rdy_full", tx_ready, 1'b0);
        send(8'hFF, 4'd8, 3'b011, 2'b10);
        @(negedge clk);
        chk("b2b_rdy_still_full", tx_ready, 1'b0);
      end
    join
    lows  = 0;
    dones = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx_out !== 1'b1) lows++;
      if (tx_done !== 1'b0) dones++;
    end
    chk("b2b_dropped_lows", lows, 0);
    chk("b2b_dropped_done", dones, 0);
    chk("b2b_idle_busy", tx_busy, 1'b0);

    // reset during data bit 3 with a second frame waiting in the holding register
    start_frame("r1", 8'hA5, 4'd8, 3'b000, 2'b00);
    send(8'h77, 4'd8, 3'b000, 2'b00);
    n   = 0;
    bud = 400;
    while (n < 66 && bud > 0) begin
      tp = tick;
      @(negedge clk);
      if (tp) n++;
      bud--;
    end
    chk("r1_reach_bit3", n, 66);
    chk("r1_mid_busy", tx_busy, 1'b1);
    chk("r1_mid_full", tx_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("r1_line", tx_out, 1'b1);
    chk("r1_busy", tx_busy, 1'b0);
    chk("r1_ready", tx_ready, 1'b1);
    chk("r1_done", tx_done, 1'b0);
    reset = 1'b0;
    lows  = 0;
    dones = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx_out !== 1'b1) lows++;
      if (tx_done !== 1'b0) dones++;
    end
    chk("r1_quiet_lows", lows, 0);
    chk("r1_quiet_done", dones, 0);

    start_frame("r2", 8'h3C, 4'd8, 3'b000, 2'b00);
    rx_frame("r2", 16'b0_0111_1000, 9, 16);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
